mux_4to1_top: RTL and testbench

- Parameterised 4:1 multiplexer built from three 2:1 mux stages: two first-level muxes feed one second-level mux.
- Both first-level (intermediate) results are exported for debug and observability.
- Combinational data path, plus a registered copy of the final output for timing-clean downstream use.
- Leaf datapath primitive; sits inside larger select/steering logic.

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux2to1.sv | 15 +
 rtl/mux_4to1_top.sv | 60 ++++++
 tb/tb_mux_4to1_top.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the 4:1 mux: select encodings and default data width.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 1;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/mux2to1.sv
// Bitwise 2:1 mux leaf: y = sel ? b : a.
module mux2to1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_4to1_top.sv
// 4:1 mux from three 2:1 stages, with debug taps and a registered output.
// Optional registered parity output o_par under MUX4TO1_PARITY_EN.
module mux_4to1_top
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] t1,
  output logic [WIDTH-1:0] t2,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q
`ifdef MUX4TO1_PARITY_EN
  ,
  output logic             o_par
`endif
);

  mux2to1 #(.WIDTH(WIDTH)) u_mux_lo (
    .a   (i0),
    .b   (i1),
    .sel (s0),
    .y   (t1)
  );

  mux2to1 #(.WIDTH(WIDTH)) u_mux_hi (
    .a   (i2),
    .b   (i3),
    .sel (s0),
    .y   (t2)
  );

  mux2to1 #(.WIDTH(WIDTH)) u_mux_out (
    .a   (t1),
    .b   (t2),
    .sel (s1),
    .y   (o)
  );

  always_ff @(posedge clk) begin
    if (rst) o_q <= '0;
    else     o_q <= o;
  end

`ifdef MUX4TO1_PARITY_EN
  // Parity shares o_q's timing so downstream sees a matched pair.
  always_ff @(posedge clk) begin
    if (rst) o_par <= 1'b0;
    else     o_par <= ^o;
  end
`endif

endmodule

// File: tb/tb_mux_4to1_top.sv
// Scoreboard bench for mux_4to1_top (WIDTH=4): directed plan cases plus
// random traffic checked against an index-based model of the 4:1 select.
module tb_mux_4to1_top;
  import mux_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i0, i1, i2, i3;
  logic         s0, s1;
  logic [W-1:0] t1, t2, o, o_q;
`ifdef MUX4TO1_PARITY_EN
  logic         o_par;
`endif

  mux_4to1_top #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .s0  (s0),
    .s1  (s1),
    .t1  (t1),
    .t2  (t2),
    .o   (o),
    .o_q (o_q)
`ifdef MUX4TO1_PARITY_EN
    ,
    .o_par (o_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] t1;
    logic [W-1:0] t2;
    logic [W-1:0] o;
    logic [W-1:0] oq;
    logic         par;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  // Reference: pick from an array by the 2-bit index 2*s1+s0.
  task automatic issue(input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic [W-1:0] a2, input logic [W-1:0] a3,
                       input logic [1:0] sel, input logic r);
    logic [W-1:0] d[4];
    exp_t e;
    int   idx;
    @(negedge clk);
    d[0] = a0; d[1] = a1; d[2] = a2; d[3] = a3;
    i0 = a0; i1 = a1; i2 = a2; i3 = a3;
    s1 = sel[1]; s0 = sel[0]; rst = r;
    idx   = 2 * int'(sel[1]) + int'(sel[0]);
    e.t1  = d[int'(sel[0])];
    e.t2  = d[2 + int'(sel[0])];
    e.o   = d[idx];
    e.oq  = r ? '0 : d[idx];
    e.par = r ? 1'b0 : ^d[idx];
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: inputs change at negedge, so just after posedge the comb
  // outputs still reflect them and o_q holds what was just captured.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("t1", t1, e.t1);
        chk("t2", t2, e.t2);
        chk("o", o, e.o);
        chk("o_q", o_q, e.oq);
`ifdef MUX4TO1_PARITY_EN
        chk("o_par", {{(W-1){1'b0}}, o_par}, {{(W-1){1'b0}}, e.par});
`endif
      end
    end
  end

  initial begin
    int guard;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0;
    s0 = 1'b0; s1 = 1'b0; rst = 1'b1;

    issue(4'h0, 4'h0, 4'h0, 4'h0, SEL_I0, 1'b1);
    issue(4'h0, 4'h0, 4'h0, 4'h0, SEL_I0, 1'b1);

    issue(4'h1, 4'h0, 4'h0, 4'h0, SEL_I0, 1'b0);
    issue(4'h0, 4'h0, 4'h0, 4'h0, SEL_I0, 1'b0);
    issue(4'h0, 4'h1, 4'h1, 4'h0, SEL_I2, 1'b0);
    issue(4'h0, 4'h0, 4'h0, 4'h0, SEL_I1, 1'b0);
    issue(4'h0, 4'h0, 4'h0, 4'h1, SEL_I3, 1'b0);

    // s1 toggles with s0 fixed: t1/t2 must not move.
    issue(4'h3, 4'hC, 4'h5, 4'hA, SEL_I1, 1'b0);
    issue(4'h3, 4'hC, 4'h5, 4'hA, SEL_I3, 1'b0);

    for (int sel = 0; sel < 4; sel++)
      for (int hot = 0; hot < 4; hot++)
        for (int b = 0; b < W; b++) begin
          logic [W-1:0] v;
          logic [W-1:0] dv[4];
          v = '0;
          v[b] = 1'b1;
          for (int k = 0; k < 4; k++) dv[k] = (k == hot) ? v : '0;
          issue(dv[0], dv[1], dv[2], dv[3], 2'(sel), 1'b0);
        end

    // Reset held two cycles while o stays non-zero, then released.
    issue(4'h7, 4'h0, 4'h0, 4'h0, SEL_I0, 1'b0);
    issue(4'h7, 4'h0, 4'h0, 4'h0, SEL_I0, 1'b1);
    issue(4'h7, 4'h0, 4'h0, 4'h0, SEL_I0, 1'b1);
    issue(4'h7, 4'h0, 4'h0, 4'h0, SEL_I0, 1'b0);
    issue(4'hF, 4'h0, 4'h0, 4'h0, SEL_I0, 1'b0);

    for (int n = 0; n < 300; n++)
      issue(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
